// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: 80-entry round-constant table, initial hash values,
// mode and FSM encodings, and rotate helpers used by the round and schedule logic.
package sha2_pkg;

  typedef enum logic [1:0] {
    SHA_224 = 2'b00,
    SHA_256 = 2'b01,
    SHA_384 = 2'b10,
    SHA_512 = 2'b11
  } sha_type_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_LOAD, ST_EXPAND, ST_UPDATE, ST_DIGEST
  } sha2_state_e;

  // 64-bit constants; the 32-bit modes use the upper half of the first 64 entries.
  localparam logic [63:0] SHA2_K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [255:0] IV_224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] IV_384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [511:0] IV_512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  // H0 lands in [511:448]; 32-bit IVs are zero-extended into each 64-bit slot.
  function automatic logic [511:0] sha2_iv(input sha_type_e ty);
    logic [511:0] v;
    v = '0;
    case (ty)
      SHA_224: for (int i = 0; i < 8; i++) v[511-64*i -: 64] = {32'h0, IV_224[255-32*i -: 32]};
      SHA_256: for (int i = 0; i < 8; i++) v[511-64*i -: 64] = {32'h0, IV_256[255-32*i -: 32]};
      SHA_384: v = IV_384;
      default: v = IV_512;
    endcase
    return v;
  endfunction

  function automatic logic is_64bit(input sha_type_e ty);
    return (ty == SHA_384) || (ty == SHA_512);
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] rotr32(input logic [31:0] x, input int unsigned n);
    return {32'h0, (x >> n) | (x << (32 - n))};
  endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// Message schedule: 16-word sliding W window that supplies Wt each round,
// either from the incoming beat or from the small-sigma expansion.
module sha2_msg_sched
  import sha2_pkg::*;
(
  input  logic        axis_aclk,
  input  logic        reset,
  input  logic        mode64,
  input  logic        load_en,
  input  logic        expand_en,
  input  logic [63:0] din,
  output logic [63:0] w_out
);

  logic [63:0] win_q [16];
  logic [63:0] win_d [16];
  logic [63:0] mask, s0, s1, w_calc;

  // win_q[15] is W(t-1), so W(t-2)=[14], W(t-7)=[9], W(t-15)=[1], W(t-16)=[0].
  always_comb begin
    mask = mode64 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    s0 = mode64 ? (rotr64(win_q[1], 1) ^ rotr64(win_q[1], 8) ^ (win_q[1] >> 7))
                : (rotr32(win_q[1][31:0], 7) ^ rotr32(win_q[1][31:0], 18) ^
                   {32'h0, win_q[1][31:0] >> 3});
    s1 = mode64 ? (rotr64(win_q[14], 19) ^ rotr64(win_q[14], 61) ^ (win_q[14] >> 6))
                : (rotr32(win_q[14][31:0], 17) ^ rotr32(win_q[14][31:0], 19) ^
                   {32'h0, win_q[14][31:0] >> 10});
    w_calc = (s1 + win_q[9] + s0 + win_q[0]) & mask;
    w_out  = expand_en ? w_calc : (din & mask);
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load_en || expand_en) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_out;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: rtl/sha2_sched_hcu.sv
// SHA-224/256/384/512 hash core fed by a pre-padded AXI-Stream message,
// one compression round per cycle, single-beat 512-bit digest output.
module sha2_sched_hcu
  import sha2_pkg::*;
#(
  parameter int TUSER_WIDTH  = 128,
  parameter int SHA_TYPE_POS = 0
) (
  input  logic                   axis_aclk,
  input  logic                   reset,
  input  logic [63:0]            s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [511:0]           m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  sha2_state_e            state_q, state_d;
  sha_type_e              type_q, type_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [63:0]            h_q [8], h_d [8];
  logic [63:0]            wv_q [8], wv_d [8];
  logic [6:0]             t_q, t_d;
  logic                   fin_q, fin_d;
  logic [511:0]           dig_q, dig_d;

  logic         mode64, accept, expanding, last_round;
  logic [63:0]  mask, w_t, k_t, t1, t2, ch, maj, s0_big, s1_big;
  logic [63:0]  sum_h [8];
  logic [511:0] iv;

  assign mode64     = is_64bit(type_q);
  assign accept     = (state_q == ST_LOAD) && s_axis_tvalid;
  assign expanding  = (state_q == ST_EXPAND);
  assign last_round = (t_q == (mode64 ? 7'd79 : 7'd63));
  assign mask       = mode64 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;

  sha2_msg_sched u_sched (
    .axis_aclk (axis_aclk),
    .reset     (reset),
    .mode64    (mode64),
    .load_en   (accept),
    .expand_en (expanding),
    .din       (s_axis_tdata),
    .w_out     (w_t)
  );

  // Working registers: wv_q[0..7] = A..H.
  always_comb begin
    k_t    = mode64 ? SHA2_K[t_q] : {32'h0, SHA2_K[t_q][63:32]};
    s1_big = mode64 ? (rotr64(wv_q[4], 14) ^ rotr64(wv_q[4], 18) ^ rotr64(wv_q[4], 41))
                    : (rotr32(wv_q[4][31:0], 6) ^ rotr32(wv_q[4][31:0], 11) ^
                       rotr32(wv_q[4][31:0], 25));
    s0_big = mode64 ? (rotr64(wv_q[0], 28) ^ rotr64(wv_q[0], 34) ^ rotr64(wv_q[0], 39))
                    : (rotr32(wv_q[0][31:0], 2) ^ rotr32(wv_q[0][31:0], 13) ^
                       rotr32(wv_q[0][31:0], 22));
    ch  = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    maj = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1  = (wv_q[7] + s1_big + ch + k_t + w_t) & mask;
    t2  = (s0_big + maj) & mask;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_sum
    assign sum_h[gi] = (h_q[gi] + wv_q[gi]) & mask;
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    tuser_d = tuser_q;
    t_d     = t_q;
    fin_d   = fin_q;
    dig_d   = dig_q;
    iv      = '0;
    for (int i = 0; i < 8; i++) begin
      h_d[i]  = h_q[i];
      wv_d[i] = wv_q[i];
    end
    case (state_q)
      ST_IDLE: if (s_axis_tvalid) begin
        tuser_d = s_axis_tuser;
        type_d  = sha_type_e'(s_axis_tuser[SHA_TYPE_POS +: 2]);
        iv      = sha2_iv(type_d);
        for (int i = 0; i < 8; i++) h_d[i] = iv[511-64*i -: 64];
        fin_d   = 1'b0;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        for (int i = 0; i < 8; i++) wv_d[i] = h_q[i];
        t_d     = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD, ST_EXPAND: if (accept || expanding) begin
        wv_d[0] = (t1 + t2) & mask;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = (wv_q[3] + t1) & mask;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
        t_d     = t_q + 7'd1;
        if (accept && s_axis_tlast)  fin_d   = 1'b1;
        if (accept && t_q == 7'd15)  state_d = ST_EXPAND;
        if (expanding && last_round) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = sum_h[i];
        t_d = '0;
        if (fin_q) begin
          case (type_q)
            SHA_224: dig_d = {sum_h[0][31:0], sum_h[1][31:0], sum_h[2][31:0], sum_h[3][31:0],
                              sum_h[4][31:0], sum_h[5][31:0], sum_h[6][31:0], 288'h0};
            SHA_256: dig_d = {sum_h[0][31:0], sum_h[1][31:0], sum_h[2][31:0], sum_h[3][31:0],
                              sum_h[4][31:0], sum_h[5][31:0], sum_h[6][31:0], sum_h[7][31:0],
                              256'h0};
            SHA_384: dig_d = {sum_h[0], sum_h[1], sum_h[2], sum_h[3], sum_h[4], sum_h[5], 128'h0};
            default: dig_d = {sum_h[0], sum_h[1], sum_h[2], sum_h[3],
                              sum_h[4], sum_h[5], sum_h[6], sum_h[7]};
          endcase
          state_d = ST_DIGEST;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_DIGEST: if (m_axis_tready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= SHA_224;
      tuser_q <= '0;
      t_q     <= '0;
      fin_q   <= 1'b0;
      dig_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wv_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      tuser_q <= tuser_d;
      t_q     <= t_d;
      fin_q   <= fin_d;
      dig_q   <= dig_d;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= h_d[i];
        wv_q[i] <= wv_d[i];
      end
    end
  end

  assign s_axis_tready = (state_q == ST_LOAD);
  assign m_axis_tvalid = (state_q == ST_DIGEST);
  assign m_axis_tlast  = (state_q == ST_DIGEST);
  assign m_axis_tdata  = dig_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_sha2_sched_hcu.sv
// Directed bench for sha2_sched_hcu: reference SHA-2 vectors in all four modes,
// input gaps, output back-pressure, early tlast and a reset in the middle of a block.
module tb_sha2_sched_hcu;

  localparam int TW = 128;

  logic            axis_aclk = 1'b0;
  logic            reset;
  logic [63:0]     s_axis_tdata;
  logic [TW-1:0]   s_axis_tuser;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0]    m_axis_tdata;
  logic [TW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] msg [32];

  always #5 axis_aclk = ~axis_aclk;

  sha2_sched_hcu #(.TUSER_WIDTH(TW), .SHA_TYPE_POS(0)) dut (
    .axis_aclk     (axis_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the beat was taken.
  task automatic send_beat(input logic [63:0] word, input logic last);
    int cnt = 0;
    s_axis_tdata  = word;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && cnt < 200) begin
      @(negedge axis_aclk);
      cnt++;
    end
    if (!s_axis_tready) check("beat_accept_timeout", 0, 1);
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // tuser is inverted after the first beat, so a design that resamples it would be caught.
  task automatic send_msg(input int nwords, input int last_idx, input logic [TW-1:0] tu,
                          input bit gaps);
    s_axis_tuser = tu;
    for (int i = 0; i < nwords; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge axis_aclk);
      send_beat(msg[i], (i == last_idx));
      s_axis_tuser = ~tu;
    end
  endtask

  task automatic wait_digest(input string name, input logic [511:0] exp,
                             input logic [TW-1:0] exp_tu, input int exp_lat, input int stall);
    int lat = 0;
    while (!m_axis_tvalid && lat < 300) begin
      @(negedge axis_aclk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_tdata"}, m_axis_tdata, exp);
    check({name, "_tuser"}, m_axis_tuser, exp_tu);
    check({name, "_tlast"}, m_axis_tlast, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge axis_aclk);
      check({name, "_stall_valid"}, m_axis_tvalid, 1);
      check({name, "_stall_data"}, m_axis_tdata, exp);
    end
    m_axis_tready = 1'b1;
    @(negedge axis_aclk);
    check({name, "_single_beat"}, m_axis_tvalid, 0);
    $display("digest %s: latency %0d tdata %h", name, lat, exp);
  endtask

  task automatic load_abc(input bit wide, input logic [31:0] junk);
    for (int i = 0; i < 32; i++) msg[i] = {junk, 32'h0};
    if (wide) msg[0] = 64'h6162638000000000;
    else      msg[0] = {junk, 32'h61626380};
    msg[15] = wide ? 64'h18 : {junk, 32'h00000018};
  endtask

  localparam logic [255:0] D256_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [223:0] D224_ABC =
    224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  localparam logic [511:0] D512_ABC =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [383:0] D384_ABC =
    384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7;
  localparam logic [255:0] D256_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    logic [31:0] two_blk [16];
    int spurious;
    two_blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge axis_aclk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    reset = 1'b0;
    @(negedge axis_aclk);

    load_abc(1'b0, 32'h0);
    send_msg(16, 15, 128'h0000_c0de_0000_0001, 1'b0);
    wait_digest("sha256_abc", {D256_ABC, 256'h0}, 128'h0000_c0de_0000_0001, 49, 0);

    // Junk in the upper half of each beat, tlast on beat 5 of 16.
    load_abc(1'b0, 32'hdeadbeef);
    send_msg(16, 4, 128'h0000_0224_0000_0000, 1'b0);
    wait_digest("sha224_abc_early_tlast", {D224_ABC, 288'h0}, 128'h0000_0224_0000_0000, 49, 0);

    load_abc(1'b1, 32'h0);
    send_msg(16, 15, 128'h0000_0512_0000_0003, 1'b0);
    wait_digest("sha512_abc", D512_ABC, 128'h0000_0512_0000_0003, 65, 0);

    load_abc(1'b1, 32'h0);
    send_msg(16, 15, 128'hffff_0384_0000_0002, 1'b0);
    wait_digest("sha384_abc", {D384_ABC, 128'h0}, 128'hffff_0384_0000_0002, 65, 0);

    for (int i = 0; i < 32; i++) msg[i] = '0;
    for (int i = 0; i < 16; i++) msg[i] = {32'h0, two_blk[i]};
    msg[31] = 64'h1c0;
    m_axis_tready = 1'b0;
    send_msg(32, 31, 128'h0000_0002_b10c_0005, 1'b1);
    wait_digest("sha256_two_block", {D256_TWO, 256'h0}, 128'h0000_0002_b10c_0005, 49, 5);

    // Reset ten cycles into expansion of a finished block; nothing may come out.
    load_abc(1'b0, 32'h0);
    send_msg(16, 15, 128'h0000_0000_0000_0001, 1'b0);
    repeat (10) @(negedge axis_aclk);
    reset = 1'b1;
    repeat (2) @(negedge axis_aclk);
    reset = 1'b0;
    check("midrst_s_tready", s_axis_tready, 0);
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_m_tdata", m_axis_tdata, 0);
    spurious = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid) spurious++;
    end
    check("midrst_no_spurious_digest", spurious, 0);
    send_msg(16, 15, 128'h0000_0000_0a11_0001, 1'b0);
    wait_digest("sha256_abc_after_reset", {D256_ABC, 256'h0}, 128'h0000_0000_0a11_0001, 49, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha2_sched_hcu.md
SHA2_SCHED_HCU -- requirements
Module: sha2_sched_hcu

Interface
REQ-001 Parameter TUSER_WIDTH, default 128, width of s_axis_tuser and m_axis_tuser.
REQ-002 Parameter SHA_TYPE_POS, default 0, bit offset in s_axis_tuser of the 2-bit sha_type field.
REQ-003 axis_aclk  in  1  clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  in  64  message word; bits [31:0] are used in 32-bit modes.
REQ-006 s_axis_tuser  in  TUSER_WIDTH  sideband; sha_type is 00=SHA-224, 01=SHA-256, 10=SHA-384, 11=SHA-512.
REQ-007 s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1 each  pre-padded message stream; tlast marks the final word of the message.
REQ-008 m_axis_tdata  out  512  digest, left-aligned at bit 511, zero below the digest length.
REQ-009 m_axis_tuser  out  TUSER_WIDTH  tuser captured on the first beat of the message.
REQ-010 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  single-beat digest; tlast equals tvalid.

Function
REQ-011 States SHALL be IDLE, INIT, LOAD, EXPAND, UPDATE and DIGEST.
REQ-012 IDLE: tready=0; on s_axis_tvalid, latch tuser and sha_type, load H0..H7 with the mode IV, go to INIT; no beat is consumed.
REQ-013 INIT: working registers A..H take H0..H7; round counter t takes 0; go to LOAD with tready=1 in LOAD.
REQ-014 LOAD: each accepted beat (tvalid&tready) SHALL execute round t with Wt=input word, push the word into the 16-entry schedule window and increment t.
REQ-015 LOAD: a stalled beat (tvalid=0) SHALL hold all state.
REQ-016 LOAD: the 16th accepted beat SHALL go to EXPAND with tready=0.
REQ-017 EXPAND: one round per cycle with Wt=s1(Wt-2)+Wt-7+s0(Wt-15)+Wt-16, for t=16..63 (32-bit modes) or t=16..79 (64-bit modes); go to UPDATE after the last round.
REQ-018 UPDATE: Hi += working register i; go to DIGEST if the block-finish flag is set, else go to INIT.
REQ-019 The block-finish flag SHALL be set by tlast on any accepted beat of the current block.
REQ-020 Blocks are always 16 beats: tlast before beat 16 still requires 16 beats; beats after it belong to the same block.
REQ-021 sha_type SHALL be sampled only in IDLE; tuser changes mid-message SHALL be ignored.
REQ-022 32-bit modes: all additions modulo 2^32; upper 32 bits of every register SHALL be zero; Kt is taken from the upper 32 bits of the 64-bit K table.
REQ-023 64-bit modes: all additions modulo 2^64.
REQ-024 Throughput: 16 beats + 48 (SHA-224/256) or 64 (SHA-384/512) + 2 cycles per block; m_axis_tvalid rises the cycle after the final UPDATE.
REQ-025 DIGEST: tvalid=1 and tdata stable until m_axis_tready; then go to IDLE with tvalid=0.
REQ-026 Digest packing: 224 = H0..H6[31:0] in [511:288]; 256 = H0..H7[31:0] in [511:256]; 384 = H0..H5 in [511:128]; 512 = H0..H7 in [511:0].

Reset
REQ-027 Reset SHALL force IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, t=0 and finish flag=0.
REQ-028 Reset mid-message or mid-digest SHALL discard all partial state; no digest is emitted.

Structure
REQ-029 Package sha2_pkg SHALL hold the 80x64 K table, the four IV sets, the sha_type encoding and the state enum.
REQ-030 Sub-module sha2_msg_sched SHALL hold the 16-entry W window plus small-sigma logic, with shift/load/expand controls and a mode input.
REQ-031 Round logic (big Sigma, Ch, Maj, adders) SHALL stay in the top module.

Verification
REQ-032 SHA-256 "abc", one padded block, tlast on beat 16 -> ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad in [511:256], lower bits 0.
REQ-033 SHA-224 "abc" -> 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 in [511:288].
REQ-034 SHA-512 "abc" -> ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f.
REQ-035 SHA-256 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", random tvalid gaps, m_axis_tready held low 5 cycles -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, stable while stalled, exactly one digest beat.
REQ-036 SHA-384 "abc" -> cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7 in [511:128].
REQ-037 Reset asserted mid-EXPAND, then SHA-256 "abc" -> no spurious tvalid, correct ba7816bf... digest.
